// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - state enum, funct3 codes and lane-mask helpers for the load/store unit
//
// Shared by load_store_unit and lsu_align. No ports.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] width_mask(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return MASK_B;
            F3_H, F3_HU: return MASK_H;
            default:     return MASK_W;
        endcase
    endfunction

    // Stores only have signed widths; loads reject the three unassigned codes.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    endfunction

    // An access spills into the next word when any shifted lane lands above lane 3.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] offset);
        logic [7:0] mask8;
        mask8 = {4'b0000, width_mask(funct3)} << offset;
        return |mask8[7:4];
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and memory bus bundle of the load/store unit
//
// slave  : the load/store unit itself (serves CPU requests, drives the memory bus)
// master : the surrounding CPU core and memory
// CPU side   : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata, resp_valid/resp_rdata/resp_fault
// Memory side: mem_req/mem_we/mem_addr/mem_be/mem_wdata, mem_ack/mem_rdata
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifter, byte-enable generator and load extractor
//
// Ports:
//   funct3, offset   : access width code and byte offset within the word
//   second           : 1 selects the upper (next-word) half of a split access
//   wdata            : right-justified store data
//   lo_word, hi_word : read words of the first and second access
//   be, lane_wdata   : byte enables and lane-shifted store data for the selected half
//   rdata            : extracted and sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        second,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata
);

    logic [7:0]  mask8;
    logic [63:0] wide_w;
    logic [31:0] shifted;

    always_comb begin
        mask8      = {4'b0000, width_mask(funct3)} << offset;
        wide_w     = {32'b0, wdata} << {offset, 3'b000};
        be         = second ? mask8[7:4] : mask8[3:0];
        lane_wdata = second ? wide_w[63:32] : wide_w[31:0];
        // Bring the addressed byte down to bit 0 across the two-word window.
        shifted    = 32'({hi_word, lo_word} >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit with optional misaligned access splitting
//
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : load_store_unit_if.slave (CPU request/response and memory bus)
// Parameter ACK_TIMEOUT: cycles mem_req may wait for mem_ack before the access faults.
// Macro LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses are split into two
// bus accesses; when undefined they fault without touching the bus.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    lsu_state_e state, state_n;

    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          fault_q;
    logic [31:0]   rdata_q;
    logic [CW-1:0] cnt;

    logic          accept;
    logic          legal_in;
    logic          in_acc;
    logic          timeout;
    logic          second;
    logic [31:0]   word_addr;
    logic [31:0]   lo_word;
    logic [31:0]   hi_word;
    logic [3:0]    be;
    logic [31:0]   lane_wdata;
    logic [31:0]   load_data;

    assign accept    = bus.req_valid && (state == ST_IDLE);
    assign word_addr = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic          split_q;
    logic [31:0]   lo_q;

    assign legal_in = funct3_legal(bus.req_we, bus.req_funct3);
    assign split_q  = is_split(f3_q, addr_q[1:0]);
    assign in_acc   = (state == ST_ACC0) || (state == ST_ACC1);
    assign second   = (state == ST_ACC1);
    // Final load result is formed in the acking cycle, so the live bus word is used.
    assign lo_word  = (state == ST_ACC0) ? bus.mem_rdata : lo_q;
    assign hi_word  = (state == ST_ACC1) ? bus.mem_rdata : 32'b0;
`else
    assign legal_in = funct3_legal(bus.req_we, bus.req_funct3)
                      && !is_split(bus.req_funct3, bus.req_addr[1:0]);
    assign in_acc   = (state == ST_ACC0);
    assign second   = 1'b0;
    assign lo_word  = bus.mem_rdata;
    assign hi_word  = 32'b0;
`endif

    // An ack arriving on the last permitted cycle still completes the access.
    assign timeout = in_acc && !bus.mem_ack && (cnt == CNT_LAST);

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .second     (second),
        .wdata      (wdata_q),
        .lo_word    (lo_word),
        .hi_word    (hi_word),
        .be         (be),
        .lane_wdata (lane_wdata),
        .rdata      (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = legal_in ? ST_ACC0 : ST_RESP;
                end
            end
            ST_ACC0: begin
                if (bus.mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_n = split_q ? ST_ACC1 : ST_RESP;
`else
                    state_n = ST_RESP;
`endif
                end else if (timeout) begin
                    state_n = ST_RESP;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ACC1: begin
                if (bus.mem_ack || timeout) begin
                    state_n = ST_RESP;
                end
            end
`endif
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'b0;
            cnt     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            lo_q    <= 32'b0;
`endif
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                fault_q <= !legal_in;
                rdata_q <= 32'b0;
            end
            // Any state change restarts the wait count; remaining in an access
            // state implies no ack this cycle.
            if (state_n != state) begin
                cnt <= '0;
            end else if (in_acc) begin
                cnt <= cnt + CW'(1);
            end
            if (in_acc && (state_n == ST_RESP)) begin
                fault_q <= timeout;
                rdata_q <= (we_q || timeout) ? 32'b0 : load_data;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if ((state == ST_ACC0) && bus.mem_ack) begin
                lo_q <= bus.mem_rdata;
            end
`endif
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.mem_req    = in_acc;
    assign bus.mem_we     = in_acc && we_q;
    assign bus.mem_addr   = !in_acc ? 32'b0 : (second ? word_addr + 32'd4 : word_addr);
    assign bus.mem_be     = in_acc ? be : 4'b0000;
    assign bus.mem_wdata  = (in_acc && we_q) ? lane_wdata : 32'b0;
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_fault = (state == ST_RESP) && fault_q;
    assign bus.resp_rdata = (state == ST_RESP) ? rdata_q : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    load_store_unit_if bus ();

    load_store_unit #(.ACK_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for exactly one accepting cycle; returns 1 time unit
    // after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be: got %h want 0", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL rst_resp_fault: got %b want 0", bus.resp_fault); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        // Stray ack with nothing outstanding.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL stray_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL stray_mem_req: got %b want 0", bus.mem_req); end
    endtask

    task automatic test_load_byte();
        issue(1'b0, F3_B, 32'h11, 32'h0);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %b want 1", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL lb_addr: got %h want 00000010", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b0010) begin errors++; $display("FAIL lb_be: got %b want 0010", bus.mem_be); end
        bus.mem_rdata = 32'h0080_FF00;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL lb_resp_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_rdata: got %h want ffffffff", bus.resp_rdata); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL lb_fault: got %b want 0", bus.resp_fault); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL lb_req_drop: got %b want 0", bus.mem_req); end
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_after: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] rd [5];
        logic [3:0]  eb [5];
        logic [31:0] ea [5];
        logic [31:0] er [5];
        f3 = '{F3_H, F3_HU, F3_BU, F3_W, F3_B};
        ad = '{32'h02, 32'h02, 32'h13, 32'h40, 32'h10};
        rd = '{32'h8001_1234, 32'h8001_1234, 32'h9A00_0000, 32'hDEAD_BEEF, 32'h0000_007F};
        eb = '{4'b1100, 4'b1100, 4'b1000, 4'b1111, 4'b0001};
        ea = '{32'h00, 32'h00, 32'h10, 32'h40, 32'h10};
        er = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_009A, 32'hDEAD_BEEF, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, f3[i], ad[i], 32'h0);
            checks++; if (bus.mem_be !== eb[i]) begin errors++; $display("FAIL ld%0d_be: got %b want %b", i, bus.mem_be, eb[i]); end
            checks++; if (bus.mem_addr !== ea[i]) begin errors++; $display("FAIL ld%0d_addr: got %h want %h", i, bus.mem_addr, ea[i]); end
            bus.mem_rdata = rd[i];
            bus.mem_ack   = 1'b1;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_valid: got %b want 1", i, bus.resp_valid); end
            checks++; if (bus.resp_rdata !== er[i]) begin errors++; $display("FAIL ld%0d_rdata: got %h want %h", i, bus.resp_rdata, er[i]); end
        end
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3 [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        logic [3:0]  eb [2];
        logic [31:0] ew [2];
        f3 = '{F3_B, F3_H};
        ad = '{32'h05, 32'h06};
        wd = '{32'h0000_00AB, 32'h0000_1234};
        eb = '{4'b0010, 4'b1100};
        ew = '{32'h0000_AB00, 32'h1234_0000};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, f3[i], ad[i], wd[i]);
            checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL st%0d_we: got %b want 1", i, bus.mem_we); end
            checks++; if (bus.mem_be !== eb[i]) begin errors++; $display("FAIL st%0d_be: got %b want %b", i, bus.mem_be, eb[i]); end
            checks++; if (bus.mem_wdata !== ew[i]) begin errors++; $display("FAIL st%0d_wdata: got %h want %h", i, bus.mem_wdata, ew[i]); end
            bus.mem_rdata = 32'h5555_5555;
            bus.mem_ack   = 1'b1;
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL st%0d_rdata: got %h want 0", i, bus.resp_rdata); end
        end
    endtask

    task automatic test_store_split();
        issue(1'b1, F3_W, 32'h102, 32'hA1B2_C3D4);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sws_addr0: got %h want 00000100", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL sws_be0: got %b want 1100", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'hC3D4_0000) begin errors++; $display("FAIL sws_wdata0: got %h want c3d40000", bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.mem_addr !== 32'h104) begin errors++; $display("FAIL sws_addr1: got %h want 00000104", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b0011) begin errors++; $display("FAIL sws_be1: got %b want 0011", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'h0000_A1B2) begin errors++; $display("FAIL sws_wdata1: got %h want 0000a1b2", bus.mem_wdata); end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL sws_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL sws_fault: got %b want 0", bus.resp_fault); end
`else
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL sws_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL sws_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL sws_fault: got %b want 1", bus.resp_fault); end
`endif
    endtask

    task automatic test_load_split();
        issue(1'b0, F3_HU, 32'h23, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (bus.mem_addr !== 32'h20) begin errors++; $display("FAIL lhus_addr0: got %h want 00000020", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL lhus_be0: got %b want 1000", bus.mem_be); end
        bus.mem_rdata = 32'hAB00_0000;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.mem_addr !== 32'h24) begin errors++; $display("FAIL lhus_addr1: got %h want 00000024", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b0001) begin errors++; $display("FAIL lhus_be1: got %b want 0001", bus.mem_be); end
        bus.mem_rdata = 32'h0000_00CD;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_rdata !== 32'h0000_CDAB) begin errors++; $display("FAIL lhus_rdata: got %h want 0000cdab", bus.resp_rdata); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL lhus_fault: got %b want 0", bus.resp_fault); end
`else
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL lhus_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL lhus_fault: got %b want 1", bus.resp_fault); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL lhus_rdata: got %h want 0", bus.resp_rdata); end
`endif
    endtask

    task automatic test_wrap();
        issue(1'b0, F3_W, 32'hFFFF_FFFE, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", bus.mem_addr); end
        bus.mem_rdata = 32'h2211_0000;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", bus.mem_addr); end
        bus.mem_rdata = 32'h0000_4433;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_rdata !== 32'h4433_2211) begin errors++; $display("FAIL wrap_rdata: got %h want 44332211", bus.resp_rdata); end
`else
        checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL wrap_fault: got %b want 1", bus.resp_fault); end
`endif
    endtask

    task automatic test_timeout();
        int cycles;
        bit seen;
        issue(1'b0, F3_W, 32'h40, 32'h0);
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.resp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.mem_req === 1'b1) cycles++;
                @(posedge clk); #1;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL to_resp_seen: got %b want 1", seen); end
        checks++; if (cycles != 16) begin errors++; $display("FAIL to_req_cycles: got %0d want 16", cycles); end
        checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %b want 1", bus.resp_fault); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b want 0", bus.mem_req); end
        // Ack on exactly the 16th waiting cycle must complete cleanly.
        issue(1'b0, F3_W, 32'h40, 32'h0);
        repeat (15) begin @(posedge clk); #1; end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL to16_req: got %b want 1", bus.mem_req); end
        bus.mem_rdata = 32'h1234_5678;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL to16_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_fault !== 1'b0) begin errors++; $display("FAIL to16_fault: got %b want 0", bus.resp_fault); end
        checks++; if (bus.resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL to16_rdata: got %h want 12345678", bus.resp_rdata); end
    endtask

    task automatic test_reset_mid_access();
`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1'b0, F3_W, 32'h41, 32'h0);
        bus.mem_rdata = 32'h0;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL rma_acc1_addr: got %h want 00000044", bus.mem_addr); end
`else
        issue(1'b0, F3_W, 32'h40, 32'h0);
`endif
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rma_req_before: got %b want 1", bus.mem_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rma_req_async: got %b want 0", bus.mem_req); end
        @(posedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rma_valid_in_rst: got %b want 0", bus.resp_valid); end
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rma_stray_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rma_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rma_stray_valid2: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_illegal();
        logic       we [6];
        logic [2:0] f3 [6];
        we = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        f3 = '{3'b100, 3'b101, 3'b011, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 6; i++) begin
            issue(we[i], f3[i], 32'h20, 32'hFFFF_FFFF);
            checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL ill%0d_req: got %b want 0", i, bus.mem_req); end
            checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ill%0d_valid: got %b want 1", i, bus.resp_valid); end
            checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL ill%0d_fault: got %b want 1", i, bus.resp_fault); end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h80;
        @(posedge clk); #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_acc: got %b want 0", bus.req_ready); end
        bus.mem_rdata = 32'hAAAA_0001;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack  = 1'b0;
        bus.req_addr = 32'h84;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp: got %b want 0", bus.req_ready); end
        checks++; if (bus.resp_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_rdata0: got %h want aaaa0001", bus.resp_rdata); end
        @(posedge clk); #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_addr !== 32'h84) begin errors++; $display("FAIL b2b_addr1: got %h want 00000084", bus.mem_addr); end
        bus.mem_rdata = 32'hBBBB_0002;
        bus.mem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.resp_rdata !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_rdata1: got %h want bbbb0002", bus.resp_rdata); end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
        test_reset();
        test_load_byte();
        test_load_extend();
        test_store_lanes();
        test_store_split();
        test_load_split();
        test_wrap();
        test_timeout();
        test_reset_mid_access();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001: Parameter ACK_TIMEOUT, default 16; maximum cycles to wait for mem_ack per bus access before faulting.
- REQ-002: CLK  input  1  sole clock; all state updates on rising edge.
- REQ-003: Reset  input  1  asynchronous, active-high reset.
- REQ-004: req_valid  input  1  CPU access request.
- REQ-005: req_ready  output  1  unit can accept a request.
- REQ-006: req_we  input  1  1 = store, 0 = load.
- REQ-007: req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-008: req_addr  input  32  byte address.
- REQ-009: req_wdata  input  32  store data, right-justified.
- REQ-010: resp_valid  output  1  one-cycle completion pulse.
- REQ-011: resp_rdata  output  32  extended load data; 0 for stores and faults.
- REQ-012: resp_fault  output  1  qualified by resp_valid: illegal funct3, misalignment, or timeout.
- REQ-013: mem_req, mem_we  output  1 each  bus request and write strobe.
- REQ-014: mem_addr  output  32  word-aligned address, bits [1:0] = 0.
- REQ-015: mem_be  output  4  byte-lane enables; bit n = byte n.
- REQ-016: mem_wdata  output  32  lane-shifted store data.
- REQ-017: mem_ack  input  1  bus completion; mem_rdata is valid in the same cycle.
- REQ-018: mem_rdata  input  32  bus read word.

Function
- REQ-019: FSM states: IDLE, ACC0, ACC1, RESP; req_ready=1 only in IDLE.
- REQ-020: A request is accepted when req_valid&&req_ready; request fields are latched in that cycle.
- REQ-021: After acceptance, the FSM goes to ACC0 if the request is legal, else to RESP with fault and no bus access.
- REQ-022: Illegal funct3 values: 011, 110, 111 for loads; any value other than 000/001/010 for stores.
- REQ-023: Offset o = addr[1:0]. An access is split when (H and o==3) or (W and o!=0).
- REQ-024: ACC0 drives word addr&~3 with the low 4 lanes of the 8-bit mask (width mask << o); ACC1 drives the next word (+4) with the high 4 lanes.
- REQ-025: Store data: {32'b0,wdata} << 8*o; the low half goes in ACC0 and the high half in ACC1.
- REQ-026: mem_req holds high with stable outputs until mem_ack.
- REQ-027: On mem_ack in ACC0, the FSM goes to ACC1 if split, else to RESP; on mem_ack in ACC1, it goes to RESP.
- REQ-028: Load data: {hi_word,lo_word} >> 8*o, then byte/half select; B/H sign-extend, BU/HU zero-extend.
- REQ-029: RESP lasts exactly one cycle, asserts resp_valid, then returns to IDLE. A new request is accepted no earlier than the following cycle.
- REQ-030: Unsplit latency is accept -> RESP = 2 cycles + ack wait.
- REQ-031: Timeout counter clears on entering ACC0/ACC1 and increments each non-ack cycle. When it reaches ACK_TIMEOUT, mem_req drops and the FSM enters RESP with fault.
- REQ-032: mem_ack in the same cycle the timeout is reached SHALL win (no fault).
- REQ-033: Address wrap: 0xFFFFFFFC + 4 SHALL wrap to 0x00000000.

Reset
- REQ-034: Reset forces IDLE at any time, including mid-access.
- REQ-035: Reset values: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_fault=0, resp_rdata=0, req_ready=1 after release.
- REQ-036: A mem_ack arriving after reset with no outstanding access SHALL be ignored.

Configuration
- REQ-037: LSU_MISALIGN_SPLIT_EN defined: split accesses are performed per REQ-023..028.
- REQ-038: LSU_MISALIGN_SPLIT_EN undefined: split-class accesses go straight to RESP with fault, and ACC1 is not built.

Structure
- REQ-039: Package lsu_pkg holds the state enum, funct3 constants and width-mask constants.
- REQ-040: Sub-module lsu_align is combinational and holds the lane shift, byte-enable generation and load extraction/extension.

Verification
- REQ-041: LB at 0x11, mem_rdata=0x0080FF00, ack immediate -> single access at 0x10, be=0010, resp_rdata=0xFFFFFFFF, resp_fault=0.
- REQ-042: SW 0xA1B2C3D4 at 0x102 with split enabled -> access 0x100 be=1100 wdata=0xC3D40000, then 0x104 be=0011 wdata=0x0000A1B2, with no fault.
- REQ-043: LHU at 0x23 split, words 0xAB000000 and 0x000000CD -> resp_rdata=0x0000CDAB. With the macro undefined, the same access gives resp_fault=1 and mem_req never asserts.
- REQ-044: LW at 0x40 with ack withheld -> mem_req drops after 16 cycles and resp_fault=1. Ack on exactly the 16th cycle -> no fault.
- REQ-045: Reset asserted during ACC1 -> mem_req=0 asynchronously, no resp_valid, and a subsequent stray mem_ack is ignored.
- REQ-046: Store with funct3=100 -> resp_fault=1 on the cycle after acceptance, with no bus activity.
